// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and MEM; MEM wins ties until IF has lost MAX_MEM_STREAK grants in a row.
// Bus request is registered one cycle after arbitration; ready pulses one cycle after i_bus_ready; requesters stall until ready.
module mem_port_arbiter #(
  parameter int DATA_W         = 32,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [DATA_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [DATA_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_bus_valid,
  output logic              o_bus_we,
  output logic [DATA_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_stall_if,
  output logic              o_stall_mem
);

  localparam int                  STREAK_W   = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_we_q, bus_we_d;
  logic [DATA_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                mem_ready_q, mem_ready_d;

  logic if_vld, mem_vld, streak_full, grant_if, grant_mem;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;

    // A requester still holding req during its own ready pulse is not a new request.
    if_vld      = i_if_req & ~if_ready_q;
    mem_vld     = i_mem_req & ~mem_ready_q;
    streak_full = (streak_q == STREAK_MAX);
    grant_mem   = 1'b0;
    grant_if    = 1'b0;

    case (state_q)
      IDLE: begin
        grant_mem = mem_vld & ~(if_vld & streak_full);
        grant_if  = if_vld & ~grant_mem;
        if (grant_mem) begin
          state_d     = BUSY_MEM;
          bus_valid_d = 1'b1;
          bus_we_d    = i_mem_we;
          bus_addr_d  = i_mem_addr;
          bus_wdata_d = i_mem_wdata;
          if (if_vld) begin
            streak_d = streak_full ? streak_q : streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
          end
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = i_if_addr;
          streak_d    = '0;
        end
      end
      BUSY_IF: begin
        if (i_bus_ready) begin
          state_d     = IDLE;
          bus_valid_d = 1'b0;
          if_rdata_d  = i_bus_rdata;
          if_ready_d  = 1'b1;
        end
      end
      BUSY_MEM: begin
        if (i_bus_ready) begin
          state_d     = IDLE;
          bus_valid_d = 1'b0;
          mem_ready_d = 1'b1;
          if (!bus_we_q) begin
            mem_rdata_d = i_bus_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign o_bus_valid = bus_valid_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_mem_rdata = mem_rdata_q;
  assign o_if_ready  = if_ready_q;
  assign o_mem_ready = mem_ready_q;
  assign o_stall_if  = i_if_req & ~if_ready_q;
  assign o_stall_mem = i_mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder with programmable wait states, grant/ready scoreboard,
// transaction table plus cycle-exact sequences for latency, masking, reset and starvation.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_ready;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_ready;
  logic        o_bus_valid;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready = 1'b0;
  logic [31:0] i_bus_rdata = 32'h0;
  logic        o_stall_if;
  logic        o_stall_mem;

  mem_port_arbiter #(.DATA_W(32), .MAX_MEM_STREAK(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .o_mem_rdata(o_mem_rdata), .o_mem_ready(o_mem_ready),
    .o_bus_valid(o_bus_valid), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
  typedef struct { logic st; logic [31:0] data; } mexp_t;
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    int          wait_c;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;
  } vec_t;

  gnt_t        exp_gnt_q[$];
  logic [31:0] exp_if_q[$];
  mexp_t       exp_mem_q[$];

  int          wait_cfg = 0;
  int          wcnt = 0;
  int          vld_len = 0;
  logic        vld_prev = 1'b0;
  logic        ifr_prev = 1'b0;
  logic        memr_prev = 1'b0;
  logic [31:0] last_load = 32'h0;
  gnt_t        g;
  gnt_t        held;
  mexp_t       m;

  // Memory responder and scoreboard, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_gnt_q.delete();
      exp_if_q.delete();
      exp_mem_q.delete();
      last_load   = 32'h0;
      vld_prev    = 1'b0;
      vld_len     = 0;
      ifr_prev    = 1'b0;
      memr_prev   = 1'b0;
      wcnt        = 0;
      i_bus_ready = 1'b0;
    end else begin
      if (o_bus_valid && !vld_prev) begin
        vld_len = 1;
        chk("grant_expected", 32'(exp_gnt_q.size() > 0), 1);
        if (exp_gnt_q.size() > 0) begin
          g = exp_gnt_q.pop_front();
          chk("gnt_we", 32'(o_bus_we), 32'(g.we));
          chk("gnt_addr", o_bus_addr, g.addr);
          if (g.we) chk("gnt_wdata", o_bus_wdata, g.wdata);
        end
        held = '{we: o_bus_we, addr: o_bus_addr, wdata: o_bus_wdata};
      end else if (o_bus_valid) begin
        vld_len++;
        chk("bus_we_stable", 32'(o_bus_we), 32'(held.we));
        chk("bus_addr_stable", o_bus_addr, held.addr);
        chk("bus_wdata_stable", o_bus_wdata, held.wdata);
      end else if (vld_prev) begin
        chk("bus_valid_len", 32'(vld_len), 32'(wait_cfg + 1));
      end

      if (o_if_ready) begin
        chk("if_ready_one_cycle", 32'(ifr_prev), 0);
        chk("if_ready_expected", 32'(exp_if_q.size() > 0), 1);
        if (exp_if_q.size() > 0) chk("if_rdata", o_if_rdata, exp_if_q.pop_front());
      end
      if (o_mem_ready) begin
        chk("mem_ready_one_cycle", 32'(memr_prev), 0);
        chk("mem_ready_expected", 32'(exp_mem_q.size() > 0), 1);
        if (exp_mem_q.size() > 0) begin
          m = exp_mem_q.pop_front();
          if (!m.st) last_load = m.data;
          chk("mem_rdata", o_mem_rdata, last_load);
        end
      end
      chk("stall_if", 32'(o_stall_if), 32'(i_if_req & ~o_if_ready));
      chk("stall_mem", 32'(o_stall_mem), 32'(i_mem_req & ~o_mem_ready));

      if (o_bus_valid && wcnt == wait_cfg) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = mem_model(o_bus_addr);
        wcnt        = 0;
      end else begin
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'hBAD0_BAD0;
        wcnt        = o_bus_valid ? wcnt + 1 : 0;
      end
      vld_prev  = o_bus_valid;
      ifr_prev  = o_if_ready;
      memr_prev = o_mem_ready;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // which: 0 = if ready, 1 = mem ready, 2 = bus valid
  task automatic wait_for(input int which, input string nm);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      tick();
      case (which)
        0:       seen = o_if_ready;
        1:       seen = o_mem_ready;
        default: seen = o_bus_valid;
      endcase
    end
    if (!seen) chk(nm, 32'(seen), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic if_pend, mem_pend;
    int   if_cyc, mem_cyc;
    wait_cfg = v.wait_c;
    tick();
    i_if_req    = v.if_req;
    i_if_addr   = v.if_addr;
    i_mem_req   = v.mem_req;
    i_mem_we    = v.mem_we;
    i_mem_addr  = v.mem_addr;
    i_mem_wdata = v.mem_wdata;
    if (v.mem_req) begin
      exp_gnt_q.push_back('{we: v.mem_we, addr: v.mem_addr, wdata: v.mem_wdata});
      exp_mem_q.push_back('{st: v.mem_we, data: v.exp_mem_rdata});
    end
    if (v.if_req) begin
      exp_gnt_q.push_back('{we: 1'b0, addr: v.if_addr, wdata: 32'h0});
      exp_if_q.push_back(v.exp_if_rdata);
    end
    if_pend  = v.if_req;
    mem_pend = v.mem_req;
    if_cyc   = -1;
    mem_cyc  = -1;
    for (int c = 0; c < 80 && (if_pend || mem_pend); c++) begin
      tick();
      if (if_pend && o_if_ready) begin i_if_req = 1'b0; if_pend = 1'b0; if_cyc = c; end
      if (mem_pend && o_mem_ready) begin i_mem_req = 1'b0; mem_pend = 1'b0; mem_cyc = c; end
    end
    chk($sformatf("vec%0d_complete", idx), 32'(if_pend | mem_pend), 0);
    if (v.if_req && v.mem_req) chk($sformatf("vec%0d_mem_before_if", idx), 32'(mem_cyc < if_cyc), 1);
    tick();
  endtask

  vec_t vecs[6];
  int   nready;
  logic mem_win;

  initial begin
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,    0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2000, 32'h0,    1, 32'h0,        32'h3234DFFF};
    vecs[2] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0,    0, 32'h1330FEFB, 32'h3234DFFF};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40,   32'h55AA, 3, 32'h0,        32'h0};
    vecs[4] = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h300,  32'hCAFE, 2, 32'h1034FDFF, 32'h0};
    vecs[5] = '{1'b1, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0,    5, 32'h1234FFFF, 32'h0};

    i_rst_n = 1'b0; i_if_req = 1'b0; i_if_addr = 32'h0;
    i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_addr = 32'h0; i_mem_wdata = 32'h0;
    #12;
    chk("rst_bus_valid", 32'(o_bus_valid), 0);
    chk("rst_bus_we", 32'(o_bus_we), 0);
    chk("rst_bus_addr", o_bus_addr, 0);
    chk("rst_bus_wdata", o_bus_wdata, 0);
    chk("rst_if_rdata", o_if_rdata, 0);
    chk("rst_mem_rdata", o_mem_rdata, 0);
    chk("rst_if_ready", 32'(o_if_ready), 0);
    chk("rst_mem_ready", 32'(o_mem_ready), 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    tick();

    // Lone IF read, cycle-exact latency.
    wait_cfg = 0;
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h100;
    exp_gnt_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_if_q.push_back(32'hDEADBEEF);
    @(negedge i_clk);
    chk("a_c0_stall_if", 32'(o_stall_if), 1);
    chk("a_c0_bus_valid", 32'(o_bus_valid), 0);
    @(negedge i_clk);
    chk("a_c1_bus_valid", 32'(o_bus_valid), 1);
    chk("a_c1_bus_addr", o_bus_addr, 32'h100);
    chk("a_c1_bus_we", 32'(o_bus_we), 0);
    chk("a_c1_stall_if", 32'(o_stall_if), 1);
    @(negedge i_clk);
    chk("a_c2_if_ready", 32'(o_if_ready), 1);
    chk("a_c2_if_rdata", o_if_rdata, 32'hDEADBEEF);
    chk("a_c2_stall_if", 32'(o_stall_if), 0);
    tick();
    i_if_req = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Masking: IF keeps req through its ready pulse with a new address.
    wait_cfg = 0;
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h100;
    exp_gnt_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_gnt_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    exp_if_q.push_back(32'hDEADBEEF);
    exp_if_q.push_back(32'h1330FEFB);
    wait_for(0, "b_first_ready");
    i_if_addr = 32'h104;
    @(negedge i_clk) chk("b_pulse_no_bus", 32'(o_bus_valid), 0);
    @(negedge i_clk) chk("b_p1_no_bus", 32'(o_bus_valid), 0);
    @(negedge i_clk);
    chk("b_p2_bus_valid", 32'(o_bus_valid), 1);
    chk("b_p2_bus_addr", o_bus_addr, 32'h104);
    wait_for(0, "b_second_ready");
    i_if_req = 1'b0;
    tick();

    // Reset while BUSY_MEM.
    wait_cfg = 6;
    tick();
    i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h2000;
    exp_gnt_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0});
    exp_mem_q.push_back('{st: 1'b0, data: 32'h3234DFFF});
    wait_for(2, "c_bus_busy");
    tick();
    #2 i_rst_n = 1'b0;
    #1;
    chk("c_rst_valid_async", 32'(o_bus_valid), 0);
    chk("c_rst_bus_addr", o_bus_addr, 0);
    i_mem_req = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    wait_cfg = 0;
    nready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_if_ready || o_mem_ready) nready++;
    end
    chk("c_no_ready_after_rst", 32'(nready), 0);
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h104;
    exp_gnt_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    exp_if_q.push_back(32'h1330FEFB);
    @(negedge i_clk) chk("c_idle_c0_valid", 32'(o_bus_valid), 0);
    @(negedge i_clk) chk("c_idle_c1_valid", 32'(o_bus_valid), 1);
    wait_for(0, "c_if_ready");
    i_if_req = 1'b0;
    tick();

    // Starvation bound: both request together each round, IF withdraws if it loses.
    wait_cfg = 1;
    for (int k = 0; k < 6; k++) begin
      mem_win = (k != 4);
      tick();
      i_if_req = 1'b1; i_if_addr = 32'h500 + 32'(k * 4);
      i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h600 + 32'(k * 4);
      if (mem_win) begin
        exp_gnt_q.push_back('{we: 1'b0, addr: i_mem_addr, wdata: 32'h0});
        exp_mem_q.push_back('{st: 1'b0, data: mem_model(i_mem_addr)});
      end else begin
        exp_gnt_q.push_back('{we: 1'b0, addr: i_if_addr, wdata: 32'h0});
        exp_if_q.push_back(mem_model(i_if_addr));
      end
      tick();
      i_if_req = 1'b0; i_mem_req = 1'b0;
      wait_for(mem_win ? 1 : 0, $sformatf("d_round%0d_ready", k));
      tick();
    end

    repeat (3) tick();
    chk("end_gnt_q_empty", 32'(exp_gnt_q.size()), 0);
    chk("end_if_q_empty", 32'(exp_if_q.size()), 0);
    chk("end_mem_q_empty", 32'(exp_mem_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the pipeline's instruction-fetch stage (IF) and its memory stage (MEM, lw/sw). Each requester uses a request/ready handshake; the memory uses a valid/ready bus with variable latency. MEM has priority, and a bounded-streak counter prevents IF starvation. The block produces per-stage stall signals for the hazard logic.

## Interface
- `DATA_W`, 32: data and address width.
- `MAX_MEM_STREAK`, 4: maximum consecutive MEM grants while IF is waiting before IF is forced a grant; must be at least 1.

- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_if_req` input 1: IF requests an instruction read.
- `i_if_addr` input DATA_W: IF read address.
- `o_if_rdata` output DATA_W: registered instruction word.
- `o_if_ready` output 1: one-cycle pulse; `o_if_rdata` is valid.
- `i_mem_req` input 1: MEM requests an access.
- `i_mem_we` input 1: 1 = store, 0 = load.
- `i_mem_addr` input DATA_W: MEM address.
- `i_mem_wdata` input DATA_W: store data.
- `o_mem_rdata` output DATA_W: registered load data.
- `o_mem_ready` output 1: one-cycle pulse; the MEM access is complete.
- `o_bus_valid` output 1: a bus transaction is active.
- `o_bus_we` output 1: bus write enable.
- `o_bus_addr` output DATA_W: bus address.
- `o_bus_wdata` output DATA_W: bus write data.
- `i_bus_ready` input 1: memory completes the transaction this cycle.
- `i_bus_rdata` input DATA_W: memory read data; valid when `i_bus_ready` is high.
- `o_stall_if` output 1: `i_if_req & ~o_if_ready` (combinational).
- `o_stall_mem` output 1: `i_mem_req & ~o_mem_ready` (combinational).

## Operation
- **FSM states:** IDLE, BUSY_IF, BUSY_MEM.
- **Requester rule:** a requester holds `req`, address, `we` and `wdata` stable until its ready pulse.
- **Masking:** a requester whose ready output is high this cycle is masked; its `req` is ignored for arbitration in that cycle.
- **IDLE, arbitration on the unmasked requests:**
  - Only IF requesting: grant IF.
  - Only MEM requesting: grant MEM.
  - Both requesting: grant MEM, unless `streak == MAX_MEM_STREAK`, in which case grant IF.
- **On grant:** register the address, `we` and `wdata` onto the `o_bus_*` signals (IF grant forces `we = 0`). Set `o_bus_valid = 1` and move to BUSY_IF or BUSY_MEM.
- **BUSY_x:** the `o_bus_*` signals stay stable. On an edge where `i_bus_ready` is 1:
  - `o_bus_valid` goes to 0.
  - For a read, `i_bus_rdata` is registered into `o_x_rdata`; on a store, `o_mem_rdata` holds its previous value.
  - `o_x_ready` goes to 1 for exactly one cycle and the FSM returns to IDLE.
- **`i_bus_ready`** is ignored while `o_bus_valid` is 0.
- **Streak counter** (width `$clog2(MAX_MEM_STREAK+1)`), updated at the grant edge:
  - MEM grant with unmasked IF request pending: increment, saturating at MAX.
  - MEM grant with no IF request pending: clear to 0.
  - IF grant: clear to 0.

## Timing
- **Reset** (asynchronous, on `i_rst_n` low):
  - FSM to IDLE and `streak` to 0.
  - `o_bus_valid`, `o_bus_we`, `o_if_ready` and `o_mem_ready` to 0.
  - `o_bus_addr`, `o_bus_wdata`, `o_if_rdata` and `o_mem_rdata` to 0.
- **Reset mid-transaction:** the transaction is abandoned and `o_bus_valid` drops immediately without waiting for the clock. No ready pulse is issued after reset.
- **Minimum latency with zero-wait memory:**
  - Request seen in IDLE at cycle 0.
  - `o_bus_valid` high in cycle 1; `i_bus_ready` is also high in cycle 1.
  - `o_x_ready` high in cycle 2.
  - Earliest next grant is in cycle 3 for the same requester, or cycle 2 for the other requester.
- **Wait states:** each cycle `i_bus_ready` stays low adds one cycle of latency.
- **Request dropped mid-transaction:** if `req` drops while BUSY (a protocol violation), the transaction still completes and the ready pulse is still issued.
- **Stalls:** `o_stall_*` stay high from the request cycle through the cycle before the ready pulse, and are low during the pulse cycle.

## Test plan
- **Lone IF read:** `i_if_req = 1`, `i_if_addr = 0x100`, memory returns `0xDEADBEEF` with zero wait → `o_bus_valid` in cycle 1 with `o_bus_addr = 0x100`, `o_bus_we = 0`; `o_if_ready = 1` and `o_if_rdata = 0xDEADBEEF` in cycle 2; `o_stall_if` high in cycles 0–1.
- **Simultaneous requests:** IF (`0x104`) and MEM load (`0x2000`) asserted together → MEM granted first; IF transaction follows; `o_mem_ready` precedes `o_if_ready`.
- **Starvation bound:** both requesters held high continuously, `MAX_MEM_STREAK = 4`, MEM re-requesting after every ready → grant sequence is M, M, M, M, I, M, … and `streak` returns to 0 after the I grant.
- **Store with wait states:** MEM store to `0x40` with data `0x55AA`, `i_bus_ready` delayed 3 cycles → bus signals stable for 4 cycles with `o_bus_we = 1`; single `o_mem_ready` pulse; `o_mem_rdata` unchanged.
- **Reset mid-transaction:** assert `i_rst_n = 0` while in BUSY_MEM → `o_bus_valid` drops without a clock edge; after release, no ready pulse and the FSM is in IDLE.
- **Masking:** IF holds `req` high through its ready pulse with a new address → no re-grant in the pulse cycle; new bus transaction appears 2 cycles after the pulse.
